// File: rtl/pes_icg_pkg.sv
// Shared constants for the pes_icg clock-gating demonstrator.
`timescale 1ns/1ps
package pes_icg_pkg;

  localparam int unsigned WIDTH_DEFAULT = 1;

endpackage

// File: rtl/pes_icg_if.sv
// Enable/data/result bundle for pes_icg. The master drives the enable and data, and the slave returns both registers.
`timescale 1ns/1ps
interface pes_icg_if
  import pes_icg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             in;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;

  modport master (output in, output d0, output d1, input q0, input q1);
  modport slave  (input in, input d0, input d1, output q0, output q1);

endinterface

// File: rtl/pes_icg_icg_cell.sv
// Latch-based clock gate. A library ICG cell can replace this module at synthesis.
`timescale 1ns/1ps
module icg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);

  logic en_latch;

  // The latch is transparent only while clk is low. The enable is therefore frozen for the whole
  // high phase, so gclk pulses are always full-width or absent.
  always_latch begin
    if (!rst_n) begin
      en_latch <= 1'b0;
    end else if (!clk) begin
      en_latch <= en;
    end
  end

  assign gclk = clk & en_latch;

endmodule

// File: rtl/pes_icg.sv
// Clock-gating demonstrator: q0 runs on the gated clock, and q1 is the same register on the free clock.
`timescale 1ns/1ps
module pes_icg
  import pes_icg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  pes_icg_if.slave  bus
);

  logic             gclk;
  logic [WIDTH-1:0] q0_p0;
  logic [WIDTH-1:0] q1_p0;

  icg_cell u_icg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.in),
    .gclk  (gclk)
  );

  // ---- stage p0: gated-domain register ----
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      q0_p0 <= '0;
    end else begin
      q0_p0 <= bus.d0;
    end
  end

  // ---- stage p0: ungated reference register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_p0 <= '0;
    end else begin
      q1_p0 <= bus.d1;
    end
  end

  assign bus.q0 = q0_p0;
  assign bus.q1 = q1_p0;

endmodule

// File: tb/tb_pes_icg.sv
// Directed bench for pes_icg: reset, gating on/off, enable glitches, mid-high enable and async reset.
`timescale 1ns/1ps
module tb_pes_icg;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  realtime t_rise;
  realtime gclk_w;

  pes_icg_if #(.WIDTH(W)) bus ();

  pes_icg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #30 clk = ~clk;
  end

  initial begin
    t_rise = 0;
    gclk_w = 0;
  end
  always @(posedge dut.gclk) t_rise = $realtime;
  always @(negedge dut.gclk) gclk_w = $realtime - t_rise;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] on_d0 [4];
  logic [W-1:0] on_d1 [4];
  logic [W-1:0] off_d0 [5];
  logic [W-1:0] off_d1 [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    on_d0  = '{4'hA, 4'hC, 4'h1, 4'h9};
    on_d1  = '{4'h2, 4'hD, 4'h4, 4'h8};
    off_d0 = '{4'h3, 4'hF, 4'h0, 4'h6, 4'h5};
    off_d1 = '{4'h1, 4'hE, 4'h7, 4'hB, 4'h0};

    // Reset held with the enable high and all-ones data
    rst_n = 1'b1;
    bus.in = 1'b1;
    bus.d0 = 4'hF;
    bus.d1 = 4'hF;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_q0", bus.q0, 4'h0);
      chk("rst_q1", bus.q1, 4'h0);
      chk("rst_gclk", dut.gclk, 1'b0);
    end

    // Release with the enable low
    @(negedge clk); #5;
    bus.in = 1'b0;
    bus.d1 = 4'h3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_q1", bus.q1, 4'h3);
    chk("rel_q0", bus.q0, 4'h0);
    chk("rel_gclk", dut.gclk, 1'b0);

    // Gating on
    @(negedge clk); #5;
    bus.in = 1'b1;
    bus.d0 = 4'h5;
    bus.d1 = 4'h6;
    @(posedge clk); #1;
    chk("on_q0", bus.q0, 4'h5);
    chk("on_q1", bus.q1, 4'h6);
    chk("on_gclk", dut.gclk, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #5;
      bus.d0 = on_d0[i];
      bus.d1 = on_d1[i];
      @(posedge clk); #1;
      chk("on_q0_seq", bus.q0, on_d0[i]);
      chk("on_q1_seq", bus.q1, on_d1[i]);
    end

    // Gating off for five cycles: q0 must hold 9
    @(negedge clk); #5;
    bus.in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk); #5;
      end
      bus.d0 = off_d0[i];
      bus.d1 = off_d1[i];
      @(posedge clk); #1;
      chk("off_q0_hold", bus.q0, 4'h9);
      chk("off_q1", bus.q1, off_d1[i]);
      chk("off_gclk", dut.gclk, 1'b0);
    end

    // Enable dropped during the high phase must not truncate the pulse
    @(negedge clk); #5;
    bus.in = 1'b1;
    bus.d0 = 4'h7;
    @(posedge clk); #10;
    bus.in = 1'b0;
    #5;
    chk("glt_gclk_held", dut.gclk, 1'b1);
    chk("glt_q0_a", bus.q0, 4'h7);
    @(negedge clk); #1;
    chk("glt_width_a", int'(gclk_w), 30);

    // Enable toggles in the low phase and ends high, so a full pulse is expected
    #4;
    bus.in = 1'b1;
    bus.d0 = 4'hE;
    #10 bus.in = 1'b0;
    #10 bus.in = 1'b1;
    @(posedge clk); #1;
    chk("glt_q0_b", bus.q0, 4'hE);
    chk("glt_gclk_b", dut.gclk, 1'b1);
    @(negedge clk); #1;
    chk("glt_width_b", int'(gclk_w), 30);

    // Enable toggles in the low phase and ends low, so no pulse is expected
    #4;
    bus.in = 1'b1;
    bus.d0 = 4'h2;
    #20 bus.in = 1'b0;
    @(posedge clk); #1;
    chk("glt_gclk_c", dut.gclk, 1'b0);
    chk("glt_q0_c", bus.q0, 4'hE);

    // Enable raised 10 ns into the high phase: no pulse this cycle, capture on the next edge
    #9;
    bus.in = 1'b1;
    bus.d0 = 4'hB;
    #5;
    chk("mid_gclk", dut.gclk, 1'b0);
    chk("mid_q0_hold", bus.q0, 4'hE);
    @(posedge clk); #1;
    chk("mid_q0_next", bus.q0, 4'hB);
    chk("mid_gclk_next", dut.gclk, 1'b1);

    // Async reset in the middle of a high phase
    @(negedge clk); #5;
    bus.d0 = 4'hF;
    bus.d1 = 4'hF;
    @(posedge clk); #1;
    chk("pre_q0", bus.q0, 4'hF);
    chk("pre_q1", bus.q1, 4'hF);
    #9;
    rst_n = 1'b0;
    #1;
    chk("arst_q0", bus.q0, 4'h0);
    chk("arst_q1", bus.q1, 4'h0);
    chk("arst_gclk", dut.gclk, 1'b0);
    @(posedge clk); #1;
    chk("arst_hold_q0", bus.q0, 4'h0);
    chk("arst_hold_q1", bus.q1, 4'h0);
    chk("arst_hold_gclk", dut.gclk, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
